// File: rtl/comp_pkg.sv
// Shared types for the serial magnitude comparator.
package comp_pkg;

   // Controller sequencing states.
   typedef enum logic {
      IDLE,
      SCAN
   } comp_state_t;

   // Outcome of one 2-bit slice, or of a whole compare.
   typedef enum logic [1:0] {
      CMP_LT,
      CMP_EQ,
      CMP_GT
   } cmp_res_t;

   // Collapse a one-hot slice result into the enum.
   function automatic cmp_res_t to_res(input logic lt, input logic gt);
      if (lt)      return CMP_LT;
      else if (gt) return CMP_GT;
      else         return CMP_EQ;
   endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Combinational 2-bit unsigned comparator slice with one-hot lt/eq/gt.
module cmp2_slice (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic       lt,
   output logic       eq,
   output logic       gt
);

   // Plain 2-bit magnitude compare; exactly one output is high.
   always_comb begin
      lt = (x < y);
      eq = (x == y);
      gt = (x > y);
   end

endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// Serial WIDTH-bit magnitude comparator: walks 2-bit slices MSB first
// through one shared cmp2_slice and reports a one-hot result.
module serial_mag_comp_ctrl
   import comp_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [WIDTH-1:0]               a,
   input  logic [WIDTH-1:0]               b,
   output logic                           busy,
   output logic                           done,
   output logic                           lt,
   output logic                           eq,
   output logic                           gt,
   output logic [$clog2(WIDTH/2):0]       slices
);

   localparam int NS = WIDTH / 2;
   localparam int CW = $clog2(NS) + 1;

   comp_state_t    r_state;
   logic [WIDTH-1:0] r_a, r_b;
   logic [CW-1:0]  r_cnt;
   logic [CW-1:0]  r_slices;
   logic           r_dec;
   cmp_res_t       r_pend;
   logic           r_busy, r_done, r_lt, r_eq, r_gt;

   logic           w_lt, w_eq, w_gt;
   logic           w_last, w_leave;
   cmp_res_t       w_final;

   // The single shared slice comparator sees the current top slice.
   cmp2_slice u_slice (
      .x  (r_a[WIDTH-1 -: 2]),
      .y  (r_b[WIDTH-1 -: 2]),
      .lt (w_lt),
      .eq (w_eq),
      .gt (w_gt)
   );

   // Exit decision and the result to publish on leaving SCAN; an earlier
   // pending decision always wins over the current slice.
   always_comb begin
      w_last  = (r_cnt == CW'(NS - 1));
      w_leave = EARLY_EXIT ? (w_last || !w_eq) : w_last;
      w_final = r_dec ? r_pend : to_res(w_lt, w_gt);
   end

   // Sequencer: accept, scan one slice per edge, publish result with done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_slices <= '0;
         r_dec    <= 1'b0;
         r_pend   <= CMP_EQ;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_lt     <= 1'b0;
         r_eq     <= 1'b0;
         r_gt     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_lt    <= 1'b0;
                  r_eq    <= 1'b0;
                  r_gt    <= 1'b0;
                  r_dec   <= 1'b0;
                  r_pend  <= CMP_EQ;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               r_a   <= r_a << 2;
               r_b   <= r_b << 2;
               r_cnt <= r_cnt + CW'(1);
               if (!r_dec && !w_eq) begin
                  r_dec  <= 1'b1;
                  r_pend <= to_res(w_lt, w_gt);
               end
               if (w_leave) begin
                  r_state  <= IDLE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_slices <= r_cnt + CW'(1);
                  r_lt     <= (w_final == CMP_LT);
                  r_eq     <= (w_final == CMP_EQ);
                  r_gt     <= (w_final == CMP_GT);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign lt     = r_lt;
   assign eq     = r_eq;
   assign gt     = r_gt;
   assign slices = r_slices;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Bench for serial_mag_comp_ctrl: one early-exit and one constant-latency
// instance, directed scenarios plus randomized compares against a model.
module tb_serial_mag_comp_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start1 = 1'b0, start0 = 1'b0;
   logic [7:0] a = '0, b = '0;

   logic       busy1, done1, lt1, eq1, gt1;
   logic [2:0] slices1;
   logic       busy0, done0, lt0, eq0, gt0;
   logic [2:0] slices0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_mag_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a), .b(b),
      .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1), .slices(slices1)
   );

   serial_mag_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .a(a), .b(b),
      .busy(busy0), .done(done0), .lt(lt0), .eq(eq0), .gt(gt0), .slices(slices0)
   );

   // Reference: result from integer compare; latency from first differing
   // 2-bit digit (MSB first), or full width when constant latency.
   function automatic void model(input logic [7:0] xa, input logic [7:0] xb,
                                 input bit ee, output logic [2:0] res,
                                 output int k);
      int d;
      d = -1;
      for (int i = 0; i < 4; i++)
         if (d < 0 && (((xa >> (6 - 2*i)) & 8'd3) != ((xb >> (6 - 2*i)) & 8'd3)))
            d = i;
      res = {xa < xb, xa == xb, xa > xb};
      k = (ee && d >= 0) ? d + 1 : 4;
   endfunction

   task automatic snap(input bit ee, output logic bz, output logic dn,
                       output logic [2:0] res, output logic [2:0] sl);
      if (ee) begin bz = busy1; dn = done1; res = {lt1, eq1, gt1}; sl = slices1; end
      else    begin bz = busy0; dn = done0; res = {lt0, eq0, gt0}; sl = slices0; end
   endtask

   task automatic set_start(input bit ee, input logic v);
      if (ee) start1 = v; else start0 = v;
   endtask

   // Waits for done after an accepting edge and checks latency and result.
   task automatic wait_check(input string nm, input bit ee,
                             input logic [7:0] xa, input logic [7:0] xb);
      logic bz, dn; logic [2:0] res, sl, eres; int k, n;
      model(xa, xb, ee, eres, k);
      n = 0;
      snap(ee, bz, dn, res, sl);
      n_cmp++;
      if (bz !== 1'b1 || dn !== 1'b0 || res !== 3'b000) begin
         n_err++;
         $display("FAIL %s scan_start busy=%b done=%b lt/eq/gt=%b want busy=1 done=0 000", nm, bz, dn, res);
      end
      do begin
         @(posedge clk); #1;
         n++;
         snap(ee, bz, dn, res, sl);
      end while (!dn && n < 20);
      n_cmp++;
      if (n !== k) begin
         n_err++;
         $display("FAIL %s latency got %0d want %0d (a=%h b=%h)", nm, n, k, xa, xb);
      end
      n_cmp++;
      if (bz !== 1'b0 || res !== eres || sl !== 3'(k)) begin
         n_err++;
         $display("FAIL %s result busy=%b lt/eq/gt=%b slices=%0d want busy=0 %b %0d (a=%h b=%h)",
                  nm, bz, res, sl, eres, k, xa, xb);
      end
   endtask

   // One full compare with a single-cycle start, plus done-pulse/hold check.
   task automatic run_cmp(input string nm, input bit ee,
                          input logic [7:0] xa, input logic [7:0] xb);
      logic bz, dn; logic [2:0] res, sl, eres; int k;
      model(xa, xb, ee, eres, k);
      @(negedge clk);
      a = xa; b = xb; set_start(ee, 1'b1);
      @(posedge clk); #1;
      set_start(ee, 1'b0);
      a = ~xa; b = ~xb;
      wait_check(nm, ee, xa, xb);
      @(posedge clk); #1;
      snap(ee, bz, dn, res, sl);
      n_cmp++;
      if (dn !== 1'b0 || bz !== 1'b0 || res !== eres || sl !== 3'(k)) begin
         n_err++;
         $display("FAIL %s hold done=%b busy=%b lt/eq/gt=%b slices=%0d want 0 0 %b %0d",
                  nm, dn, bz, res, sl, eres, k);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy1, done1, lt1, eq1, gt1, slices1, busy0, done0, lt0, eq0, gt0, slices0} !== '0) begin
         n_err++;
         $display("FAIL reset outputs ee1=%b%b%b%b%b/%0d ee0=%b%b%b%b%b/%0d want all 0",
                  busy1, done1, lt1, eq1, gt1, slices1, busy0, done0, lt0, eq0, gt0, slices0);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_directed();
      run_cmp("eq_A5", 1'b1, 8'hA5, 8'hA5);
      run_cmp("lt_slice0", 1'b1, 8'h40, 8'h80);
      run_cmp("gt_slice3", 1'b1, 8'hA7, 8'hA6);
      run_cmp("const_lat_gt", 1'b0, 8'hC0, 8'h00);
      run_cmp("const_lat_eq", 1'b0, 8'h3C, 8'h3C);
   endtask

   task automatic test_random();
      logic [7:0] xa, xb;
      for (int i = 0; i < 60; i++) begin
         xa = 8'($urandom);
         xb = ($urandom_range(0, 3) == 0) ? xa : 8'($urandom);
         if ($urandom_range(0, 1) == 0) xb = (xa & 8'hF0) | (xb & 8'h0F);
         run_cmp("random", bit'(i % 2), xa, xb);
      end
   endtask

   // start held high with changing operands: ignored while busy, taken in the done cycle.
   task automatic test_back_to_back();
      logic bz, dn; logic [2:0] res, sl; int n;
      logic [7:0] xa2, xb2;
      xa2 = 8'h1B; xb2 = 8'h2B;
      @(negedge clk);
      a = 8'h00; b = 8'h00; start1 = 1'b1;
      @(posedge clk); #1;
      n = 0;
      do begin
         @(negedge clk); a = 8'($urandom) | 8'h80; b = 8'($urandom) & 8'h7F;
         @(posedge clk); #1; n++;
      end while (!done1 && n < 20);
      snap(1'b1, bz, dn, res, sl);
      n_cmp++;
      if (n !== 4 || res !== 3'b010 || sl !== 3'd4) begin
         n_err++;
         $display("FAIL b2b_first latency=%0d lt/eq/gt=%b slices=%0d want 4 010 4", n, res, sl);
      end
      @(negedge clk); a = xa2; b = xb2;
      @(posedge clk); #1;
      start1 = 1'b0;
      wait_check("b2b_second", 1'b1, xa2, xb2);
   endtask

   task automatic test_reset_mid_scan();
      logic seen; logic [2:0] res;
      @(negedge clk);
      a = 8'hA5; b = 8'hA5; start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      res = {lt1, eq1, gt1};
      n_cmp++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || res !== 3'b000 || slices1 !== 3'd0) begin
         n_err++;
         $display("FAIL rst_mid busy=%b done=%b lt/eq/gt=%b slices=%0d want 0 0 000 0",
                  busy1, done1, res, slices1);
      end
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin @(posedge clk); #1; if (done1 || busy1) seen = 1'b1; end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_no_done saw done/busy=%b want 0", seen);
      end
      run_cmp("after_rst_lt", 1'b1, 8'h01, 8'h02);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid_scan();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/serial_mag_comp_ctrl.md
Name: serial_mag_comp_ctrl

Overview:
Sequencer that compares two WIDTH-bit unsigned operands 2 bits per cycle, MSB slice first, through one shared 2-bit comparator slice.
- Accepts a start request and latches both operands.
- Walks slices until the result is decided or the operands are exhausted.
- Reports one-hot lt/eq/gt with a one-cycle done pulse.
- Used wherever a wide magnitude compare runs on the small comparator datapath instead of a WIDTH-wide combinational compare.

Parameters:
WIDTH, 8, operand width in bits; even, >= 2; number of slices NS = WIDTH/2
EARLY_EXIT, 1, 1 = stop at first unequal slice; 0 = always scan all NS slices (constant latency)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only while busy=0
a  input  WIDTH  operand x; sampled on accepted start
b  input  WIDTH  operand y; sampled on accepted start
busy  output  1  high while scanning
done  output  1  one-cycle pulse when the result becomes valid
lt  output  1  result a < b
eq  output  1  result a == b
gt  output  1  result a > b
slices  output  $clog2(NS)+1  number of slices consumed by the last compare

Behaviour:
- Reset: state=IDLE; busy, done, lt, eq, gt = 0; slices = 0; shift registers = 0. Reset mid-scan aborts the compare; no done is issued.
- States:
  - IDLE: waiting for start.
  - SCAN: one slice per cycle.
  - IDLE is re-entered after a decision; done is registered high for that one cycle.
- Accept: on an edge with start=1 and state=IDLE:
  - latch a, b into shift registers;
  - clear lt/eq/gt to 0 and clear the decided flag;
  - set slice counter to 0; busy=1; go to SCAN.
- start while busy is ignored, and the operands are not re-sampled.
- Start in the same cycle as done (state is IDLE) is accepted, so back-to-back compares are allowed.
- SCAN, each cycle:
  - The top 2 bits of the a-register and b-register feed cmp2_slice combinationally.
  - At the edge: counter += 1 and both registers shift left by 2.
  - First unequal slice sets the pending result (lt or gt) and the decided flag.
  - Later slices never override a pending result.
- Leaving SCAN, at the edge of the evaluated slice:
  - EARLY_EXIT=1: leave when the slice is unequal or is slice NS-1.
  - EARLY_EXIT=0: leave only after slice NS-1.
  - If no unequal slice was seen, eq=1.
  - At that edge: busy=0, done=1 for exactly one cycle, slices = counter value including that slice.
- Latency, counted from the accepting edge:
  - done is high after k further edges, where k = index of the deciding slice + 1 (EARLY_EXIT=1), or k = NS (EARLY_EXIT=0).
  - Minimum is 1 edge; maximum is NS edges.
- Results: lt/eq/gt/slices hold after done until the next accepted start. Exactly one of lt/eq/gt is high after a completed compare; all are 0 during a scan.
- WIDTH=2: single SCAN cycle, slices=1 always.
- Counter width is sized for NS; no wrap occurs because the scan stops at NS.

Decomposition:
- Package comp_pkg holds:
  - typedef enum logic {IDLE, SCAN} comp_state_t;
  - typedef enum for the slice result {CMP_LT, CMP_EQ, CMP_GT}.
- Sub-module cmp2_slice is combinational: inputs x[1:0], y[1:0]; outputs lt, eq, gt, one-hot. It is the shared 2-bit comparator datapath; the controller instantiates exactly one.
- Controller holds the FSM, shift registers, counter and result registers.

Test Plan:
1. WIDTH=8, EARLY_EXIT=1, a=8'hA5, b=8'hA5, start 1 cycle -> busy for 4 cycles; done pulses once after the 4th scan edge; eq=1, lt=gt=0, slices=4.
2. a=8'h40, b=8'h80 -> decided at slice 0; done one edge after accept; lt=1, slices=1; results held until the next start.
3. a=8'hA7, b=8'hA6 -> slices 0-2 equal, slice 3 (11 vs 10) -> gt=1, slices=4, done after 4 edges.
4. EARLY_EXIT=0, a=8'hC0, b=8'h00 -> slice 0 decides gt, scan continues; done after exactly 4 edges with gt=1, slices=4.
5. Hold start=1 with new operands throughout a scan -> ignored while busy; accepted in the done cycle; the second compare completes correctly back-to-back.
6. Assert rst for 1 cycle during slice 2 of a scan -> next cycle busy=0, done=0, lt=eq=gt=0, slices=0, no done pulse; a following start (a=8'h01, b=8'h02) yields lt=1, slices=4.
